operand_fetch: RTL and testbench

//  Read-side client of the 32x32 register file: takes decoded instructions, drives both read

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_scoreboard.sv | 46 ++++
 rtl/operand_fetch.sv | 139 +++++++++++++
 tb/tb_operand_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the operand fetch slice.
// Register file geometry and the fetch-state encoding.
package cpu_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int NUM_ARCH    = 24;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_scoreboard.sv
// Pending-write scoreboard: one bit per readable register.
// Busy queries see a same-cycle write-back as already cleared.
module fetch_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW   = ADDR_W,
  parameter int NREG = NUM_ARCH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy
);

  logic [NREG-1:0] sb;

  // Set is applied after clear so a same-edge pair leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb <= '0;
    end else begin
      if (clr_en && int'(clr_addr) < NREG)
        sb[clr_addr] <= 1'b0;
      if (set_en && int'(set_addr) < NREG)
        sb[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    q1_busy = 1'b0;
    q2_busy = 1'b0;
    if (int'(q1_addr) < NREG)
      q1_busy = sb[q1_addr]
        && !(clr_en && clr_addr == q1_addr);
    if (int'(q2_addr) < NREG)
      q2_busy = sb[q2_addr]
        && !(clr_en && clr_addr == q2_addr);
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads both sources, stalls on pending writes,
// forwards write-back data and hands operands to execute.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DW   = DATA_W,
  parameter int AW   = ADDR_W,
  parameter int NREG = NUM_ARCH,
  parameter int SW   = STALL_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_instr,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_writes_rd,
  output logic [AW-1:0] rf_read_address1,
  output logic [AW-1:0] rf_read_address2,
  input  logic [DW-1:0] rf_data_out1,
  input  logic [DW-1:0] rf_data_out2,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_address,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_op_a,
  output logic [DW-1:0] out_op_b,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_rd,
  output logic          out_writes_rd,
  output logic [SW-1:0] stall_cycles
);

  fetch_state_e  state;
  logic [DW-1:0] lat_instr;
  logic [AW-1:0] lat_rs;
  logic [AW-1:0] lat_rt;
  logic [AW-1:0] lat_rd;
  logic          lat_wr;
  logic          rs_busy;
  logic          rt_busy;
  logic          hazard;
  logic          issue;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  assign in_ready = (state == IDLE);
  assign hazard   = rs_busy || rt_busy;
  assign issue    = (state == READ) && !hazard;

  assign rf_read_address1 = (state == IDLE) ? '0 : lat_rs;
  assign rf_read_address2 = (state == IDLE) ? '0 : lat_rt;

  fetch_scoreboard #(
    .AW   (AW),
    .NREG (NREG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue && lat_wr),
    .set_addr (lat_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_address),
    .q1_addr  (lat_rs),
    .q2_addr  (lat_rt),
    .q1_busy  (rs_busy),
    .q2_busy  (rt_busy)
  );

  // Out-of-range reads as zero; a matching write-back wins over the array.
  always_comb begin
    op_a = rf_data_out1;
    op_b = rf_data_out2;
    if (int'(lat_rs) >= NREG)
      op_a = '0;
    else if (wb_valid && wb_address == lat_rs)
      op_a = wb_data;
    if (int'(lat_rt) >= NREG)
      op_b = '0;
    else if (wb_valid && wb_address == lat_rt)
      op_b = wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lat_instr     <= '0;
      lat_rs        <= '0;
      lat_rt        <= '0;
      lat_rd        <= '0;
      lat_wr        <= 1'b0;
      out_valid     <= 1'b0;
      out_op_a      <= '0;
      out_op_b      <= '0;
      out_instr     <= '0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            lat_instr <= in_instr;
            lat_rs    <= in_rs;
            lat_rt    <= in_rt;
            lat_rd    <= in_rd;
            lat_wr    <= in_writes_rd;
            state     <= READ;
          end
        end
        READ: begin
          if (hazard) begin
            if (stall_cycles != '1)
              stall_cycles <= stall_cycles + 1'b1;
          end else begin
            out_op_a      <= op_a;
            out_op_b      <= op_b;
            out_instr     <= lat_instr;
            out_rd        <= lat_rd;
            out_writes_rd <= lat_wr;
            out_valid     <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch with a transaction-level
// model of the register file and pending-write set.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr = '0;
  logic [ADDR_W-1:0] in_rs = '0;
  logic [ADDR_W-1:0] in_rt = '0;
  logic [ADDR_W-1:0] in_rd = '0;
  logic              in_writes_rd = 1'b0;
  logic [ADDR_W-1:0] rf_read_address1;
  logic [ADDR_W-1:0] rf_read_address2;
  logic [DATA_W-1:0] rf_data_out1;
  logic [DATA_W-1:0] rf_data_out2;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_address = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_op_a;
  logic [DATA_W-1:0] out_op_b;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_rd;
  logic              out_writes_rd;
  logic [STALL_CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_rs            (in_rs),
    .in_rt            (in_rt),
    .in_rd            (in_rd),
    .in_writes_rd     (in_writes_rd),
    .rf_read_address1 (rf_read_address1),
    .rf_read_address2 (rf_read_address2),
    .rf_data_out1     (rf_data_out1),
    .rf_data_out2     (rf_data_out2),
    .wb_valid         (wb_valid),
    .wb_address       (wb_address),
    .wb_data          (wb_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_op_a         (out_op_a),
    .out_op_b         (out_op_b),
    .out_instr        (out_instr),
    .out_rd           (out_rd),
    .out_writes_rd    (out_writes_rd),
    .stall_cycles     (stall_cycles)
  );

  logic [DATA_W-1:0] rf [32];
  assign rf_data_out1 = rf[rf_read_address1];
  assign rf_data_out2 = rf[rf_read_address2];

  logic [31:0] mbusy = '0;
  int          exp_stall = 0;
  bit          quiet = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit busy_now(input int a);
    return a < NUM_ARCH && mbusy[a]
      && !(wb_valid && int'(wb_address) == a);
  endfunction

  function automatic logic [DATA_W-1:0] opnd(input int a);
    if (a >= NUM_ARCH) return '0;
    if (wb_valid && int'(wb_address) == a) return wb_data;
    return rf[a];
  endfunction

  task automatic drive_wb(input int a);
    wb_valid   = 1'b1;
    wb_address = ADDR_W'(a);
    wb_data    = $urandom;
  endtask

  task automatic rand_wb();
    if (!quiet && $urandom_range(0, 1) == 1)
      drive_wb($urandom_range(0, 31));
  endtask

  // One clock: the write-back of this cycle lands in the array and
  // releases its register in the pending set.
  task automatic tick();
    @(negedge clk);
    if (wb_valid) begin
      rf[wb_address] = wb_data;
      if (int'(wb_address) < NUM_ARCH) mbusy[wb_address] = 1'b0;
    end
    wb_valid = 1'b0;
  endtask

  task automatic run_txn(input int rs, input int rt, input int rd,
                         input bit wr, input int hold,
                         input int delay, input int wfinal);
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    bit done;
    instr = $urandom;
    done = 1'b0;
    ea = '0;
    eb = '0;
    check("idle_ready", in_ready, 1);
    check("idle_ovalid", out_valid, 0);
    check("idle_ra1", rf_read_address1, 0);
    in_valid     = 1'b1;
    in_instr     = instr;
    in_rs        = ADDR_W'(rs);
    in_rt        = ADDR_W'(rt);
    in_rd        = ADDR_W'(rd);
    in_writes_rd = wr;
    rand_wb();
    tick();
    in_valid = 1'b0;
    in_instr = $urandom;
    in_rs    = ADDR_W'($urandom);
    in_rt    = ADDR_W'($urandom);
    for (int k = 0; k < 40 && !done; k++) begin
      check("read_ready", in_ready, 0);
      check("read_ovalid", out_valid, 0);
      check("read_ra1", rf_read_address1, rs);
      check("read_ra2", rf_read_address2, rt);
      if (k >= delay && busy_now(rs))
        drive_wb(rs);
      else if (k >= delay && busy_now(rt))
        drive_wb(rt);
      else if (!busy_now(rs) && !busy_now(rt)) begin
        if (wfinal >= 0)
          drive_wb(wfinal);
        else if (wfinal == -2 && $urandom_range(0, 1) == 1)
          drive_wb($urandom_range(0, 2) == 0 ? rd :
                   $urandom_range(0, 1) == 0 ? rs :
                   $urandom_range(0, 31));
      end else
        rand_wb();
      if (!busy_now(rs) && !busy_now(rt)) begin
        ea = opnd(rs);
        eb = opnd(rt);
        done = 1'b1;
        tick();
        if (wr && rd < NUM_ARCH) mbusy[rd] = 1'b1;
      end else begin
        if (exp_stall < 65535) exp_stall++;
        tick();
      end
    end
    check("read_bound", done, 1);
    for (int h = 0; h <= hold; h++) begin
      check("hold_ovalid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_op_a", out_op_a, ea);
      check("hold_op_b", out_op_b, eb);
      check("hold_instr", out_instr, instr);
      check("hold_rd", out_rd, rd);
      check("hold_wr", out_writes_rd, wr);
      check("hold_ra1", rf_read_address1, rs);
      out_ready = (h == hold);
      rand_wb();
      tick();
    end
    out_ready = 1'b0;
    check("stall_cnt", stall_cycles, exp_stall);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    reset = 1'b1;
    tick();
    tick();
    check("rst_ready", in_ready, 1);
    check("rst_ovalid", out_valid, 0);
    check("rst_op_a", out_op_a, 0);
    check("rst_instr", out_instr, 0);
    check("rst_ra2", rf_read_address2, 0);
    check("rst_stall", stall_cycles, 0);
    reset = 1'b0;

    rf[3] = 32'd7;
    rf[4] = 32'd9;
    run_txn(3, 4, 5, 1'b1, 0, 0, -1);
    run_txn(5, 0, 6, 1'b0, 0, 3, -1);
    check("t2_stall", stall_cycles, 3);
    run_txn(30, 24, 26, 1'b1, 0, 0, 30);
    run_txn(26, 26, 1, 1'b0, 0, 2, -1);
    run_txn(1, 2, 3, 1'b1, 4, 0, -1);
    run_txn(7, 8, 3, 1'b1, 0, 0, 3);
    run_txn(3, 9, 10, 1'b0, 0, 1, -1);
    check("t5_stall", stall_cycles, 4);
    run_txn(11, 11, 12, 1'b1, 0, 0, -1);

    in_valid     = 1'b1;
    in_rs        = 5'd12;
    in_rt        = 5'd0;
    in_rd        = 5'd13;
    in_writes_rd = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mbusy = '0;
    exp_stall = 0;
    check("t6_ready", in_ready, 1);
    check("t6_ovalid", out_valid, 0);
    check("t6_stall", stall_cycles, 0);
    run_txn(12, 13, 0, 1'b0, 0, 5, -1);

    quiet = 1'b0;
    for (int t = 0; t < 200; t++)
      run_txn($urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), $urandom_range(0, 3), -2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
